// File: rtl/ts_diff_pkg.sv
// -----------------------------------------------------------------------------
// ts_diff_pkg
// Shared definitions for the transport-stream header-diff filter (ts_diff).
//   - word/data widths and frame geometry (3 header + 47 payload words)
//   - required TS sync byte
//   - delay-line stage record and the per-frame decision outcome
//   - helper to classify a frame word index as header or payload
// -----------------------------------------------------------------------------
package ts_diff_pkg;

  localparam int WORD_W      = 33;              // bus word: bit 32 = header tag
  localparam int DATA_W      = 32;              // payload data part of a word
  localparam int HDR_WORDS   = 3;               // channel ID, dest IP, dest port
  localparam int PAY_WORDS   = 47;              // one 188-byte TS packet
  localparam int FRAME_WORDS = HDR_WORDS + PAY_WORDS;
  localparam int LAT         = HDR_WORDS + 1;   // input-to-output latency
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  localparam int IDX_W = $clog2(FRAME_WORDS);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_LAST   = idx_t'(FRAME_WORDS - 1);
  // First payload word: every header word is already in the delay line here.
  localparam idx_t IDX_DECIDE = idx_t'(HDR_WORDS);

  // One delay-line stage: data word, its position in the frame, whether the
  // slot holds a real sampled word, and whether that word may be emitted.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    idx_t              idx;
    logic              valid;
    logic              keep;
  } stage_t;

  // What happens to the frame at its decision point.
  typedef enum logic [1:0] {
    DEC_NONE,      // not at a decision point
    DEC_EMIT,      // new header: forward header and payload
    DEC_SUPPRESS,  // repeated header: forward payload only
    DEC_DROP       // bad sync byte: forward nothing of this frame
  } decision_e;

  function automatic logic is_hdr(input idx_t idx);
    return idx < idx_t'(HDR_WORDS);
  endfunction

endpackage

// File: rtl/ts_diff_hdr_cmp.sv
// -----------------------------------------------------------------------------
// ts_diff_hdr_cmp
// Holds the most recently accepted frame header and flags whether a candidate
// header differs from it.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset (forgets the stored header)
//   hdr_i      in   candidate header, word 0 in element 0
//   update_i   in   store hdr_i as the accepted header on this edge
//   changed_o  out  1 when nothing is stored yet or any word differs
// -----------------------------------------------------------------------------
module ts_diff_hdr_cmp
  import ts_diff_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [HDR_WORDS-1:0][DATA_W-1:0]  hdr_i,
  input  logic                              update_i,
  output logic                              changed_o
);

  logic [HDR_WORDS-1:0][DATA_W-1:0] hdr_q;
  logic                             valid_q;

  // NOTE: sequential state is always assigned with <= so every register in the
  // design samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else if (update_i) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: the stored header itself has no reset; valid_q gates every use of
  // it, so whatever it holds before the first update is never looked at.
  always_ff @(posedge clk) begin
    if (update_i) begin
      hdr_q <= hdr_i;
    end
  end

  assign changed_o = !valid_q || (hdr_i != hdr_q);

endmodule

// File: rtl/ts_diff.sv
// -----------------------------------------------------------------------------
// ts_diff
// Transport-stream framing filter. Frames are 3 header words followed by 47
// payload words. Payload is always forwarded; the header is forwarded (tagged
// with bit 32) only when it differs from the last accepted header. Every word
// leaves exactly LAT (4) clocks after it is sampled, or not at all.
//
// Build option:
//   TS_DIFF_SYNC_CHECK_EN  defined   -> frames whose first payload word lacks
//                                       the 0x47 sync byte are dropped whole
//                          undefined -> sync byte not checked
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-low reset
//   ts_din      in   33-bit word; bit 32 reserved/ignored, [31:0] data
//   ts_din_en   in   input word valid; low aborts the frame in progress
//   ts_dout     out  33-bit word; bit 32 = 1 on header words; holds when idle
//   ts_dout_en  out  output word valid
// -----------------------------------------------------------------------------
module ts_diff
  import ts_diff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] ts_din,
  input  logic              ts_din_en,
  output logic [WORD_W-1:0] ts_dout,
  output logic              ts_dout_en
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  idx_t              cnt_q, cnt_d;
  stage_t            stage_q [LAT];    // [0] = newest (stage 1), [LAT-1] = stage 4
  stage_t            stage_d [LAT];
  logic              frame_keep_q, frame_keep_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              dout_en_q, dout_en_d;

  logic                             decide;
  logic                             sync_ok;
  logic                             changed;
  logic                             hdr_keep;
  logic                             in_keep;
  decision_e                        dec;
  logic [HDR_WORDS-1:0][DATA_W-1:0] hdr_win;

  // Reserved input bit carries no information.
  logic unused_rsvd;
  assign unused_rsvd = ts_din[WORD_W-1];

  // ---------------------------------------------------------------------------
  // Header window: at the decision point stage 3 holds header word 0, stage 1
  // holds header word 2.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < HDR_WORDS; i++) begin
      hdr_win[i] = stage_q[HDR_WORDS-1-i].data;
    end
  end

  ts_diff_hdr_cmp u_hdr_cmp (
    .clk       (clk),
    .rst       (rst),
    .hdr_i     (hdr_win),
    .update_i  (hdr_keep),
    .changed_o (changed)
  );

`ifdef TS_DIFF_SYNC_CHECK_EN
  assign sync_ok = (ts_din[DATA_W-1:DATA_W-8] == SYNC_BYTE);
`else
  assign sync_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before any condition, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    cnt_d        = '0;
    dec          = DEC_NONE;
    hdr_keep     = 1'b0;
    in_keep      = 1'b0;
    frame_keep_d = frame_keep_q;
    dout_d       = dout_q;
    dout_en_d    = 1'b0;

    // Counter runs only while words stream in; any idle clock aborts the frame.
    if (ts_din_en) begin
      cnt_d = (cnt_q == IDX_LAST) ? '0 : cnt_q + 1'b1;
    end

    // The counter only reaches IDX_DECIDE after HDR_WORDS consecutive enabled
    // words, so the header window is guaranteed to hold this frame's header.
    decide = ts_din_en && (cnt_q == IDX_DECIDE);

    if (decide) begin
      if (!sync_ok)     dec = DEC_DROP;
      else if (changed) dec = DEC_EMIT;
      else              dec = DEC_SUPPRESS;
    end

    hdr_keep = (dec == DEC_EMIT);
    if (dec != DEC_NONE) begin
      frame_keep_d = (dec != DEC_DROP);
    end

    // Header words enter unkept and are only released at the decision point,
    // so a frame aborted before it never emits a partial header.
    if (cnt_q == IDX_DECIDE)     in_keep = sync_ok;
    else if (!is_hdr(cnt_q))     in_keep = frame_keep_q;

    stage_d[0].data  = ts_din[DATA_W-1:0];
    stage_d[0].idx   = cnt_q;
    stage_d[0].valid = ts_din_en;
    stage_d[0].keep  = ts_din_en && in_keep;

    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
      // Header words are moving from stages 1..3 into 2..4 on this edge.
      if (decide) begin
        stage_d[i].keep = hdr_keep;
      end
    end

    if (stage_q[LAT-1].valid && stage_q[LAT-1].keep) begin
      dout_en_d = 1'b1;
      dout_d    = {is_hdr(stage_q[LAT-1].idx), stage_q[LAT-1].data};
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      frame_keep_q <= 1'b0;
      dout_q       <= '0;
      dout_en_q    <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      frame_keep_q <= frame_keep_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign ts_dout    = dout_q;
  assign ts_dout_en = dout_en_q;

endmodule

// File: tb/tb_ts_diff.sv
// -----------------------------------------------------------------------------
// tb_ts_diff
// Directed bench for ts_diff. Each clock the bench drives one input word and
// records the hand-derived output expected for it; that expectation is checked
// five falling edges later (sampled at edge k, registered out at edge k+4).
// -----------------------------------------------------------------------------
module tb_ts_diff;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] ts_din;
  logic        ts_din_en;
  logic [32:0] ts_dout;
  logic        ts_dout_en;

  always #5 clk = ~clk;

  ts_diff dut (
    .clk        (clk),
    .rst        (rst),
    .ts_din     (ts_din),
    .ts_din_en  (ts_din_en),
    .ts_dout    (ts_dout),
    .ts_dout_en (ts_dout_en)
  );

  typedef struct packed {
    logic        en;
    logic [32:0] word;
  } exp_t;

  exp_t        pipe [5];
  logic [32:0] exp_dout;
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  string       phase  = "reset";

`ifdef TS_DIFF_SYNC_CHECK_EN
  localparam bit SYNC_CHK = 1'b1;
`else
  localparam bit SYNC_CHK = 1'b0;
`endif

  // One clock: check what is due now, then drive the next input word.
  task automatic tick(input logic r, input logic en, input logic [31:0] d,
                      input logic e_en, input logic [32:0] e_word);
    @(negedge clk);
    if (pipe[4].en) exp_dout = pipe[4].word;
    n_cmp++;
    assert (ts_dout_en === pipe[4].en) else begin
      n_fail++;
      $error("FAIL %s dout_en cyc=%0d got=%b exp=%b", phase, cyc, ts_dout_en, pipe[4].en);
    end
    n_cmp++;
    assert (ts_dout === exp_dout) else begin
      n_fail++;
      $error("FAIL %s dout cyc=%0d got=%h exp=%h", phase, cyc, ts_dout, exp_dout);
    end
    for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0]   = '{en: e_en, word: e_word};
    rst       = r;
    ts_din_en = en;
    ts_din    = {1'b1, d};   // reserved bit driven high: must never leak out
    if (!r) begin
      for (int i = 0; i < 5; i++) pipe[i] = '0;
      exp_dout = '0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 32'h0, 1'b0, 33'h0);
  endtask

  // Sends the first nwords words of a frame: h0..h2, p0, then 1, 2, 3 ...
  // eh / ep: whether header / payload words are expected at the output.
  task automatic send_frame(input logic [31:0] h0, input logic [31:0] h1,
                            input logic [31:0] h2, input logic [31:0] p0,
                            input int nwords, input logic eh, input logic ep);
    logic [31:0] d;
    for (int i = 0; i < nwords; i++) begin
      if (i == 0)      d = h0;
      else if (i == 1) d = h1;
      else if (i == 2) d = h2;
      else if (i == 3) d = p0;
      else             d = 32'(i - 3);
      tick(1'b1, 1'b1, d, (i < 3) ? eh : ep, {(i < 3), d});
    end
  endtask

  localparam logic [31:0] SYNC_W = 32'h4700_0000;
  localparam logic [31:0] BAD_W  = 32'h4600_0000;

  initial begin
    rst       = 1'b0;
    ts_din_en = 1'b0;
    ts_din    = '0;
    exp_dout  = '0;
    for (int i = 0; i < 5; i++) pipe[i] = '0;
    repeat (2) @(posedge clk);

    // Reset state: outputs zero while rst held low.
    phase = "reset";
    tick(1'b0, 1'b0, 32'h0, 1'b0, 33'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 33'h0);
    idle(3);

    // First frame after reset: everything emitted.
    phase = "first_frame";
    send_frame(32'h1, 32'hC012_0801, 32'h21, SYNC_W, 50, 1'b1, 1'b1);
    idle(10);

    // Identical frame: header suppressed.
    phase = "repeat_hdr";
    send_frame(32'h1, 32'hC012_0801, 32'h21, SYNC_W, 50, 1'b0, 1'b1);
    idle(6);

    // New destination: header emitted again.
    phase = "new_dest";
    send_frame(32'h1, 32'hC012_0802, 32'h21, SYNC_W, 50, 1'b1, 1'b1);
    idle(6);

    // Bad sync, unchanged header.
    phase = "bad_sync_same";
    send_frame(32'h1, 32'hC012_0802, 32'h21, BAD_W, 50, 1'b0, !SYNC_CHK);
    idle(6);

    // Bad sync, different header: stored header only moves without the check.
    phase = "bad_sync_new";
    send_frame(32'h2, 32'hC012_0803, 32'h22, BAD_W, 50, !SYNC_CHK, !SYNC_CHK);
    idle(6);

    phase = "after_bad_sync";
    send_frame(32'h1, 32'hC012_0802, 32'h21, SYNC_W, 50, !SYNC_CHK, 1'b1);
    idle(6);

    // Back-to-back frames with different headers: 100 outputs, no gap.
    phase = "back_to_back";
    send_frame(32'h1, 32'hC012_0801, 32'h21, SYNC_W, 50, 1'b1, 1'b1);
    send_frame(32'h1, 32'hC012_0802, 32'h21, SYNC_W, 50, 1'b1, 1'b1);
    idle(6);

    // Abort inside the header: nothing emitted, stored header untouched.
    phase = "abort_hdr";
    send_frame(32'h3, 32'hC012_0804, 32'h23, SYNC_W, 3, 1'b0, 1'b0);
    idle(3);
    phase = "after_abort_hdr";
    send_frame(32'h1, 32'hC012_0802, 32'h21, SYNC_W, 50, 1'b0, 1'b1);
    idle(6);

    // Abort after the decision point: accepted words out, update stands.
    phase = "abort_pay";
    send_frame(32'h1, 32'hC012_0801, 32'h21, SYNC_W, 13, 1'b1, 1'b1);
    idle(3);
    phase = "after_abort_pay";
    send_frame(32'h1, 32'hC012_0801, 32'h21, SYNC_W, 50, 1'b0, 1'b1);
    idle(6);

    // Reset mid-frame: in-flight words lost, next header treated as new.
    phase = "reset_mid";
    send_frame(32'h1, 32'hC012_0801, 32'h21, SYNC_W, 20, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 33'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 33'h0);
    idle(2);
    phase = "after_reset";
    send_frame(32'h1, 32'hC012_0801, 32'h21, SYNC_W, 50, 1'b1, 1'b1);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_diff.md
Name: ts_diff

Overview:
- Transport-stream framing filter between the upstream word-stream source and the TS multiplexer/output path.
- Input frame: 50 words of 33 bits, qualified by ts_din_en = 3 header words (channel ID, destination IP, destination port) followed by 47 payload words (one 188-byte TS packet, sync byte 0x47 in bits [31:24] of payload word 0).
- The block forwards every payload word, tags header words with bit 32, and emits a frame's header only when it differs from the previously accepted header ("diff").
- Invalid frames are dropped.

Parameters:
- HDR_WORDS, 3, header words per frame.
- PAY_WORDS, 47, payload words per frame (188 bytes).
- SYNC_BYTE, 8'h47, required value of payload word 0 bits [31:24].
- LAT, 4, fixed input-to-output latency in clocks; must equal HDR_WORDS+1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- ts_din  in  33  input word; bit 32 reserved and ignored; bits [31:0] data.
- ts_din_en  in  1  input word valid.
- ts_dout  out  33  output word; bit 32 = 1 on header words, 0 on payload words.
- ts_dout_en  out  1  output word valid.

Behaviour:
- Reset (rst low at a clock edge):
  - ts_dout = 0, ts_dout_en = 0.
  - Word counter = 0, delay line cleared.
  - Stored-header-valid flag = 0.
- Word counter:
  - Increments on each edge where ts_din_en = 1.
  - Wraps from HDR_WORDS+PAY_WORDS-1 (49) to 0, so back-to-back frames need no idle gap.
  - Forced to 0 on any edge where ts_din_en = 0 (frame abort).
- Delay line: every accepted word enters a LAT-deep (4-stage) delay line with its counter index and a keep bit. The output is the stage-4 word, so each word appears exactly 4 clocks after it is sampled, or is suppressed.
- Decision point: the edge that samples index 3 (payload word 0). At that edge all three header words are held in stages 1-3.
  - changed = !stored_valid OR any header word [31:0] differs from the stored copy.
  - sync_ok = ts_din[31:24] == SYNC_BYTE.
- Outcomes:
  - sync_ok and changed: keep the 3 header words; update the stored header; set stored_valid.
  - sync_ok and not changed: clear keep on the 3 header words; payload kept.
  - Not sync_ok: clear keep on the 3 header words and on every payload word of this frame (indices 3..49); stored header unchanged.
- Output assembly:
  - ts_dout_en = stage-4 valid AND keep.
  - ts_dout[31:0] = data.
  - ts_dout[32] = 1 if index < 3, else 0.
  - When not enabled, ts_dout holds its last value.
- Abort before the decision point (en low at index ≤ 2): the partial header is discarded and never emitted; stored header unchanged.
- Abort after the decision point: payload words already accepted are emitted; remaining payload is lost; the stored-header update stands.
- Reset mid-frame: frame lost; all in-flight words discarded; next frame's header is treated as changed.
- Throughput: one word per clock, no backpressure.

Optional Feature:
- TS_DIFF_SYNC_CHECK_EN defined: sync-byte check active as above.
- Undefined: sync_ok is treated as always 1. No frames are dropped; only header-diff suppression applies.

Decomposition:
- Package ts_diff_pkg:
  - Word width 33.
  - HDR_WORDS, PAY_WORDS, SYNC_BYTE.
  - Frame length 50.
  - Typedef for a delay-stage record {data, idx, valid, keep}.
- One natural sub-module: ts_diff_hdr_cmp. It holds the stored 3-word header and valid flag and produces changed; update on command.

Test Plan:
- Reset then frame {1, C0120801, 00000021, 47000000, 1..46}, en continuous 50 clocks -> 50 outputs starting 4 clocks after the first input: 1_00000001, 1_C0120801, 1_00000021, 0_47000000, 0_00000001..0_0000002E.
- Identical second frame after 10 idle clocks -> only the 47 payload words (0_47000000..0_0000002E), 4-clock latency; no header words.
- Third frame with destination C0120802 -> all 50 words emitted with the new header, bit 32 set on the first 3.
- Frame with payload word 0 = 46000000, macro defined -> no output for the whole frame. Same frame with macro undefined -> all 47 payload words output; header suppressed if unchanged.
- Two frames back-to-back (100 consecutive en clocks, different headers) -> 100 outputs, second header emitted with no gap.
- en dropped after word 2, then a full frame with the previous header -> aborted words never appear; full frame's header suppressed (stored header unchanged). Assert rst low mid-frame -> ts_dout_en = 0 next clock; following frame emits its header.
